counter_updown_mod: RTL and testbench

Parametrised up/down modulo counter, the general-purpose successor to the lab's fixed down counter. Counts between MIN_VAL and MAX_VAL in either direction and wraps at both bounds. Supports a synchronous clamped load, a registered terminal-count pulse and a saturating wrap-event counter. Used as the timing/sequencing primitive for later labs: timers, clock dividers and digit counters.

---
 rtl/counter_updown_mod.sv | 59 +++++
 tb/tb_counter_updown_mod.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: up/down modulo counter wrapping between MIN_VAL and MAX_VAL.
// Define COUNTER_SAT_EN to add a sat input that holds at the bounds instead of wrapping.
module counter_updown_mod #(
    parameter int DW        = 8,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 7,
    parameter int RESET_VAL = MAX_VAL,
    parameter int WC_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ena,
    input  logic            up,
    input  logic            load,
    input  logic [DW-1:0]   load_val,
`ifdef COUNTER_SAT_EN
    input  logic            sat,
`endif
    output logic [DW-1:0]   result,
    output logic            tc,
    output logic            at_min,
    output logic            at_max,
    output logic [WC_W-1:0] wrap_cnt
);
    localparam logic [DW:0] MIN_X = (DW+1)'(MIN_VAL);
    localparam logic [DW:0] MAX_X = (DW+1)'(MAX_VAL);
    localparam logic [DW-1:0] RST_V = DW'(RESET_VAL);
    logic [DW:0] res_x, ld_x, clamped, step;
    logic        wrap, hold_sat;
    assign res_x   = {1'b0, result};
    assign ld_x    = {1'b0, load_val};
    assign at_min  = res_x == MIN_X;
    assign at_max  = res_x == MAX_X;
    assign clamped = ld_x < MIN_X ? MIN_X : ld_x > MAX_X ? MAX_X : ld_x;
    // Extra top bit keeps +1 at 2^DW-1 and -1 at 0 from aliasing back into range.
    assign step    = up ? (at_max ? MIN_X : res_x + 1'b1) : (at_min ? MAX_X : res_x - 1'b1);
    assign wrap    = up ? at_max : at_min;
`ifdef COUNTER_SAT_EN
    assign hold_sat = sat & wrap;
`else
    assign hold_sat = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result   <= RST_V;
            tc       <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            result <= clamped[DW-1:0];
            tc     <= 1'b0;
        end else if (ena && !hold_sat) begin
            result <= step[DW-1:0];
            tc     <= wrap;
            if (wrap && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + 1'b1;
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: directed checks of counter_updown_mod over several parameter sets.
module tb_counter_updown_mod;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    int total = 0, passed = 0;

    logic ena_a = 0, up_a = 0, load_a = 0, tc_a, amin_a, amax_a;
    logic [7:0] lv_a = 0, res_a;
    logic [3:0] wc_a;
    logic ena_b = 0, up_b = 0, load_b = 0, tc_b, amin_b, amax_b;
    logic [7:0] lv_b = 0, res_b;
    logic [3:0] wc_b;
    logic ena_c = 0, up_c = 0, load_c = 0, tc_c, amin_c, amax_c;
    logic [7:0] lv_c = 0, res_c;
    logic [1:0] wc_c;
    logic ena_d = 0, up_d = 0, load_d = 0, tc_d, amin_d, amax_d;
    logic [3:0] lv_d = 0, res_d;
    logic [3:0] wc_d;
`ifdef COUNTER_SAT_EN
    logic sat_a = 0;
`endif

    counter_updown_mod u_a (.clk(clk), .reset(reset), .ena(ena_a), .up(up_a), .load(load_a), .load_val(lv_a),
`ifdef COUNTER_SAT_EN
        .sat(sat_a),
`endif
        .result(res_a), .tc(tc_a), .at_min(amin_a), .at_max(amax_a), .wrap_cnt(wc_a));
    counter_updown_mod #(.MIN_VAL(3), .MAX_VAL(5), .RESET_VAL(3)) u_b (.clk(clk), .reset(reset), .ena(ena_b),
        .up(up_b), .load(load_b), .load_val(lv_b),
`ifdef COUNTER_SAT_EN
        .sat(1'b0),
`endif
        .result(res_b), .tc(tc_b), .at_min(amin_b), .at_max(amax_b), .wrap_cnt(wc_b));
    counter_updown_mod #(.MIN_VAL(0), .MAX_VAL(1), .RESET_VAL(1), .WC_W(2)) u_c (.clk(clk), .reset(reset),
        .ena(ena_c), .up(up_c), .load(load_c), .load_val(lv_c),
`ifdef COUNTER_SAT_EN
        .sat(1'b0),
`endif
        .result(res_c), .tc(tc_c), .at_min(amin_c), .at_max(amax_c), .wrap_cnt(wc_c));
    counter_updown_mod #(.DW(4), .MIN_VAL(0), .MAX_VAL(15)) u_d (.clk(clk), .reset(reset), .ena(ena_d),
        .up(up_d), .load(load_d), .load_val(lv_d),
`ifdef COUNTER_SAT_EN
        .sat(1'b0),
`endif
        .result(res_d), .tc(tc_d), .at_min(amin_d), .at_max(amax_d), .wrap_cnt(wc_d));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_a[8] = '{6, 5, 4, 3, 2, 1, 0, 7};
        int exp_b[4] = '{4, 5, 3, 4};
        #20;
        chk("rst_res", res_a, 7);
        chk("rst_tc", tc_a, 0);
        chk("rst_wc", wc_a, 0);
        ena_a = 1; up_a = 0;
        @(posedge clk); #2; reset = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("down_res%0d", i), res_a, exp_a[i]);
            chk($sformatf("down_tc%0d", i), tc_a, i == 7);
            if (i == 6) chk("down_at_min", amin_a, 1);
        end
        chk("down_wc", wc_a, 1);
        load_a = 1; lv_a = 200;
        tick();
        chk("load_clamp", res_a, 7);
        chk("load_tc", tc_a, 0);
        chk("load_wc", wc_a, 1);
        lv_a = 2;
        tick();
        chk("load_2", res_a, 2);
        load_a = 0; ena_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d", i), res_a, 2);
        end
        chk("hold_tc", tc_a, 0);
        load_a = 1; lv_a = 0; tick();
        load_a = 0; ena_a = 1; tick();
        load_a = 1; tick();
        load_a = 0; tick();
        tick(); tick(); tick();
        chk("pre_rst_res", res_a, 4);
        chk("pre_rst_wc", wc_a, 3);
        ena_a = 0;
        #2 reset = 0;
        #1;
        chk("async_res", res_a, 7);
        chk("async_wc", wc_a, 0);
        chk("async_tc", tc_a, 0);
        ena_b = 1; up_b = 1; ena_c = 1; up_c = 0; ena_d = 1; up_d = 1;
        @(posedge clk); #2; reset = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i <= 4) begin
                chk($sformatf("b_res%0d", i), res_b, exp_b[i-1]);
                chk($sformatf("b_tc%0d", i), tc_b, i == 3);
                chk($sformatf("b_at_max%0d", i), amax_b, i == 2);
                if (i == 4) ena_b = 0;
            end
            chk($sformatf("c_res%0d", i), res_c, i % 2 == 0);
            chk($sformatf("c_tc%0d", i), tc_c, i % 2 == 0);
            chk($sformatf("c_wc%0d", i), wc_c, (i / 2 > 3) ? 3 : i / 2);
            if (i == 1) begin
                chk("d_up_wrap", res_d, 0);
                chk("d_up_tc", tc_d, 1);
                chk("d_up_wc", wc_d, 1);
                up_d = 0;
            end else if (i == 2) begin
                chk("d_dn_wrap", res_d, 15);
                chk("d_dn_tc", tc_d, 1);
                chk("d_dn_wc", wc_d, 2);
                chk("d_at_max", amax_d, 1);
                ena_d = 0;
            end
        end
        load_b = 1; lv_b = 1;
        tick();
        chk("b_clamp_low", res_b, 3);
        chk("b_at_min", amin_b, 1);
        load_b = 0;
`ifdef COUNTER_SAT_EN
        reset = 0; ena_c = 0;
        @(posedge clk); #2; reset = 1;
        load_a = 1; lv_a = 1; tick();
        load_a = 0; ena_a = 1; up_a = 0; sat_a = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_res%0d", i), res_a, 0);
            chk($sformatf("sat_tc%0d", i), tc_a, 0);
            chk($sformatf("sat_wc%0d", i), wc_a, 0);
        end
        sat_a = 0;
        tick();
        chk("unsat_res", res_a, 7);
        chk("unsat_tc", tc_a, 1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
